mac_reg_responder: RTL and testbench
====================================

Name: mac_reg_responder

Overview:
- Register-bus responder on the MAC config interface: answers addr/rd/wr/writedata requests from the MAC reset sequencer (or host) with a busy-pulse handshake.
- Holds the MAC configuration registers and a self-clearing software-reset bit (command bit 13).
- Forwards addresses 0x80-0x9F to a PHY-management request port and waits for the PHY engine (or a timeout) before completing.

Parameters:
- REV, 32'h0000_0901: value returned at address 0.
- SW_RESET_CYCLES, 16: cycles command bit 13 stays set after software reset is written (range 1..255).
- PHY_TIMEOUT, 1024: cycles to wait for phy_done before forced completion (range 2..65535).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- reg_addr  in  8  register address
- reg_rd  in  1  read request (level)
- reg_wr  in  1  write request (level; wins over reg_rd)
- reg_writedata  in  32  write data
- reg_readdata  out  32  read data; valid when reg_busy falls
- reg_busy  out  1  transaction in progress
- cfg_command  out  32  command_config register
- cfg_mac_addr  out  48  {mac_1[15:0], mac_0[31:0]}
- cfg_fifo_thr  out  128  eight 16-bit thresholds, regs 7..14; reg 7 in bits [15:0]
- phy_req  out  1  PHY access strobe, one cycle
- phy_wr  out  1  1 = PHY write, 0 = PHY read
- phy_dev  out  5  mdio_addr0[4:0]
- phy_reg  out  5  reg_addr[4:0]
- phy_wdata  out  16  reg_writedata[15:0]
- phy_rdata  in  16  PHY read data; valid with phy_done
- phy_done  in  1  PHY access complete, one cycle

Behaviour:
- Reset state: all outputs 0; all registers 0; FSM in IDLE; software-reset counter 0.
- Register map (word addresses):
  - 0: REV, read-only.
  - 1: scratch, 32 bits.
  - 2: command_config, 32 bits.
  - 3: mac_0, 32 bits.
  - 4: mac_1, bits [15:0] stored, upper bits read 0.
  - 7..14: thresholds, bits [15:0] stored.
  - 15: mdio_addr0, bits [4:0] stored.
  - 0x80-0x9F: PHY window; readdata = {16'h0, phy data}.
  - Any other address: read returns 0, write ignored; completes as a local access.
- FSM states: IDLE, LOCAL, PHY_WAIT, RECOVER.
- IDLE:
  - Samples reg_wr/reg_rd, reg_addr and reg_writedata only in this state.
  - If neither request is high, stay in IDLE.
  - If a request is high and the address is in the PHY window, go to PHY_WAIT and pulse phy_req for one cycle (registered).
  - Otherwise go to LOCAL.
- LOCAL:
  - reg_busy = 1 for exactly one cycle.
  - Write commits on the exit edge; read data is registered into reg_readdata on the same edge.
  - Next state: RECOVER.
- PHY_WAIT:
  - reg_busy = 1.
  - Counter starts at 0 on entry.
  - On phy_done: read data = phy_rdata; next state RECOVER.
  - If the counter reaches PHY_TIMEOUT-1 without phy_done: read data = 16'hFFFF; next state RECOVER.
  - phy_done arriving in any other state is ignored.
- RECOVER:
  - reg_busy = 0 for exactly one cycle; no sampling (the requester updates addr/data on this edge).
  - Next state: IDLE.
- Timing:
  - Local access: request high at cycle C → busy = 1 at C+1 → busy = 0 with readdata valid at C+2 → next sample at C+3.
  - A request held high continuously produces back-to-back transactions every 3 cycles (local).
  - reg_readdata holds its value until the next transaction completes; writes leave it unchanged.
- Software reset:
  - A write to address 2 with bit 13 set stores writedata with bits 0 and 1 (tx_en/rx_en) forced to 0 and bit 13 = 1.
  - It loads the counter with SW_RESET_CYCLES; the counter decrements every cycle.
  - Bit 13 clears on the cycle the counter reaches 0.
  - Reads of address 2 during this time return bit 13 = 1.
  - A write with bit 13 = 0 while the counter is non-zero updates all other bits; bit 13 stays set and the counter keeps running.
  - A new write with bit 13 = 1 reloads the counter.
- rst in any state:
  - Return to IDLE with busy = 0 next cycle and all registers cleared.
  - A pending PHY access is abandoned; a late phy_done is ignored.

Test Plan:
- Reset, then hold reg_wr = 1 to addr 3 with 32'h06150910 → busy high 1 cycle; cfg_mac_addr[31:0] = 32'h06150910 two cycles after request; next busy rise 3 cycles after the first.
- Write addr 4 with 32'hFFFF2019, then read addr 4 → readdata = 32'h00002019 on the busy-falling cycle; cfg_mac_addr[47:32] = 16'h2019.
- Write addr 2 with 32'h04002033, then poll reads of addr 2 → bit 13 = 1 and bits [1:0] = 0 until SW_RESET_CYCLES elapse; then read value 32'h04000030.
- Write addr 15 = 32'h10, then write addr 0x84 = 1 → phy_req pulses with phy_dev = 5'h10, phy_reg = 5'h04, phy_wdata = 16'h0001, phy_wr = 1; busy stays high until phy_done is driven 20 cycles later, then falls.
- Read addr 0x80 with phy_done never asserted → busy high PHY_TIMEOUT cycles; readdata = 32'h0000FFFF.
- Assert rst mid-PHY_WAIT, then drive phy_done → busy = 0 the next cycle, all cfg outputs 0, phy_done ignored; the following request is handled normally.

Source files
------------

// File: rtl/mac_reg_responder.sv
// MAC configuration register responder: local config registers with a self-clearing
// software-reset bit, plus a window at 0x80-0x9F forwarded to an external PHY engine.
`timescale 1ns/1ps
module mac_reg_responder #(
   parameter logic [31:0] REV             = 32'h0000_0901,
   parameter int          SW_RESET_CYCLES = 16,
   parameter int          PHY_TIMEOUT     = 1024
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   reg_addr,
   input  logic         reg_rd,
   input  logic         reg_wr,
   input  logic [31:0]  reg_writedata,
   output logic [31:0]  reg_readdata,
   output logic         reg_busy,
   output logic [31:0]  cfg_command,
   output logic [47:0]  cfg_mac_addr,
   output logic [127:0] cfg_fifo_thr,
   output logic         phy_req,
   output logic         phy_wr,
   output logic [4:0]   phy_dev,
   output logic [4:0]   phy_reg,
   output logic [15:0]  phy_wdata,
   input  logic [15:0]  phy_rdata,
   input  logic         phy_done
);

   typedef enum logic [1:0] {IDLE, LOCAL, PHY_WAIT, RECOVER} state_t;

   state_t      state;
   state_t      state_nxt;

   // Request captured in IDLE; the requester may change its inputs afterwards.
   logic        op_wr;
   logic [7:0]  op_addr;
   logic [31:0] op_wdata;

   logic        req;
   logic        phy_win;
   logic        phy_timeout;
   logic [15:0] phy_cnt;

   logic [31:0] scratch;
   logic [31:0] mac_0;
   logic [15:0] mac_1;
   logic [31:14] cmd_hi;
   logic [12:0] cmd_lo;
   logic [7:0]  sw_cnt;
   logic [15:0] thr [8];
   logic [4:0]  mdio_addr0;

   logic        thr_sel;
   logic [2:0]  thr_idx;
   logic        local_wr;
   logic [31:0] local_rdata;

   assign req         = reg_wr | reg_rd;
   assign phy_win     = (reg_addr[7:5] == 3'b100);
   assign phy_timeout = (phy_cnt == 16'(PHY_TIMEOUT - 1));
   assign thr_sel     = (op_addr >= 8'd7) && (op_addr <= 8'd14);
   assign thr_idx     = 3'(op_addr - 8'd7);
   assign local_wr    = (state == LOCAL) && op_wr;

   assign reg_busy     = (state == LOCAL) || (state == PHY_WAIT);
   // The software-reset bit is exactly "countdown still running".
   assign cfg_command  = {cmd_hi, (sw_cnt != 8'd0), cmd_lo};
   assign cfg_mac_addr = {mac_1, mac_0};

   for (genvar i = 0; i < 8; i++) begin : g_thr
      assign cfg_fifo_thr[i*16 +: 16] = thr[i];
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_nxt; a missing branch would infer a latch.
      state_nxt = state;
      case (state)
         IDLE:     if (req) state_nxt = phy_win ? PHY_WAIT : LOCAL;
         LOCAL:    state_nxt = RECOVER;
         PHY_WAIT: if (phy_done || phy_timeout) state_nxt = RECOVER;
         RECOVER:  state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_wr     <= 1'b0;
         op_addr   <= '0;
         op_wdata  <= '0;
         phy_cnt   <= '0;
         phy_req   <= 1'b0;
         phy_wr    <= 1'b0;
         phy_dev   <= '0;
         phy_reg   <= '0;
         phy_wdata <= '0;
      end else begin
         phy_req <= 1'b0;
         if (state == IDLE) begin
            op_wr    <= reg_wr;
            op_addr  <= reg_addr;
            op_wdata <= reg_writedata;
            phy_cnt  <= '0;
            if (req && phy_win) begin
               phy_req   <= 1'b1;
               phy_wr    <= reg_wr;
               phy_dev   <= mdio_addr0;
               phy_reg   <= reg_addr[4:0];
               phy_wdata <= reg_writedata[15:0];
            end
         end else if (state == PHY_WAIT) begin
            phy_cnt <= phy_cnt + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scratch    <= '0;
         mac_0      <= '0;
         mac_1      <= '0;
         cmd_hi     <= '0;
         cmd_lo     <= '0;
         sw_cnt     <= '0;
         mdio_addr0 <= '0;
         // NOTE: the threshold array is eight plain flops, not a RAM, so it is reset like the rest.
         for (int i = 0; i < 8; i++) thr[i] <= '0;
      end else begin
         if (sw_cnt != 8'd0) sw_cnt <= sw_cnt - 8'd1;
         if (local_wr) begin
            case (op_addr)
               8'd1: scratch <= op_wdata;
               8'd2: begin
                  cmd_hi <= op_wdata[31:14];
                  cmd_lo <= op_wdata[12:0];
                  // NOTE: the later non-blocking assignment to the same bits wins, overriding the plain store.
                  if (op_wdata[13]) begin
                     cmd_lo[1:0] <= 2'b00;
                     sw_cnt      <= 8'(SW_RESET_CYCLES);
                  end
               end
               8'd3:  mac_0      <= op_wdata;
               8'd4:  mac_1      <= op_wdata[15:0];
               8'd15: mdio_addr0 <= op_wdata[4:0];
               default: if (thr_sel) thr[thr_idx] <= op_wdata[15:0];
            endcase
         end
      end
   end

   always_comb begin
      local_rdata = '0;
      case (op_addr)
         8'd0:    local_rdata = REV;
         8'd1:    local_rdata = scratch;
         8'd2:    local_rdata = cfg_command;
         8'd3:    local_rdata = mac_0;
         8'd4:    local_rdata = {16'h0, mac_1};
         8'd15:   local_rdata = {27'h0, mdio_addr0};
         default: if (thr_sel) local_rdata = {16'h0, thr[thr_idx]};
      endcase
   end

   // Read data only moves when a read completes; writes leave the last value visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         reg_readdata <= '0;
      end else if (!op_wr) begin
         if (state == LOCAL) begin
            reg_readdata <= local_rdata;
         end else if (state == PHY_WAIT) begin
            if (phy_done)         reg_readdata <= {16'h0, phy_rdata};
            else if (phy_timeout) reg_readdata <= 32'h0000_FFFF;
         end
      end
   end

endmodule

// File: tb/tb_mac_reg_responder.sv
// Directed bench for mac_reg_responder: a transaction-level register model drives the
// expected outputs, and a negedge process compares every cycle.
`timescale 1ns/1ps
module tb_mac_reg_responder;

   localparam logic [31:0] REV             = 32'h0000_0901;
   localparam int          SW_RESET_CYCLES = 16;
   localparam int          PHY_TIMEOUT     = 1024;

   logic         clk;
   logic         rst;
   logic [7:0]   reg_addr;
   logic         reg_rd;
   logic         reg_wr;
   logic [31:0]  reg_writedata;
   logic [31:0]  reg_readdata;
   logic         reg_busy;
   logic [31:0]  cfg_command;
   logic [47:0]  cfg_mac_addr;
   logic [127:0] cfg_fifo_thr;
   logic         phy_req;
   logic         phy_wr;
   logic [4:0]   phy_dev;
   logic [4:0]   phy_reg;
   logic [15:0]  phy_wdata;
   logic [15:0]  phy_rdata;
   logic         phy_done;

   mac_reg_responder #(
      .REV(REV), .SW_RESET_CYCLES(SW_RESET_CYCLES), .PHY_TIMEOUT(PHY_TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .reg_addr(reg_addr), .reg_rd(reg_rd), .reg_wr(reg_wr), .reg_writedata(reg_writedata),
      .reg_readdata(reg_readdata), .reg_busy(reg_busy),
      .cfg_command(cfg_command), .cfg_mac_addr(cfg_mac_addr), .cfg_fifo_thr(cfg_fifo_thr),
      .phy_req(phy_req), .phy_wr(phy_wr), .phy_dev(phy_dev), .phy_reg(phy_reg),
      .phy_wdata(phy_wdata), .phy_rdata(phy_rdata), .phy_done(phy_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register model
   logic [31:0] m_scratch, m_cmd, m_mac0;
   logic [15:0] m_mac1;
   logic [15:0] m_thr [7:14];
   logic [4:0]  m_mdio;
   int          m_sw;

   // Expected handshake / PHY port values
   logic        exp_busy, exp_phy_req, exp_phy_wr;
   logic [4:0]  exp_phy_dev, exp_phy_reg;
   logic [15:0] exp_phy_wdata;
   logic [31:0] exp_readdata;

   int checks;
   int errors;
   bit chk_en;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [127:0] thr_vec();
      logic [127:0] v = '0;
      for (int a = 7; a <= 14; a++) v[(a-7)*16 +: 16] = m_thr[a];
      return v;
   endfunction

   function automatic logic [31:0] model_read(input logic [7:0] a);
      case (a) inside
         8'd0:          return REV;
         8'd1:          return m_scratch;
         8'd2:          return m_cmd;
         8'd3:          return m_mac0;
         8'd4:          return {16'h0, m_mac1};
         [8'd7:8'd14]:  return {16'h0, m_thr[a]};
         8'd15:         return {27'h0, m_mdio};
         default:       return 32'h0;
      endcase
   endfunction

   task automatic model_write(input logic [7:0] a, input logic [31:0] d);
      case (a) inside
         8'd1: m_scratch = d;
         8'd2: begin
            if (d[13]) begin
               m_cmd = d & ~32'h3;
               m_sw  = SW_RESET_CYCLES;
            end else begin
               m_cmd = (m_sw > 0) ? (d | 32'h0000_2000) : d;
            end
         end
         8'd3:         m_mac0 = d;
         8'd4:         m_mac1 = d[15:0];
         [8'd7:8'd14]: m_thr[a] = d[15:0];
         8'd15:        m_mdio = d[4:0];
         default: ;
      endcase
   endtask

   task automatic model_reset();
      m_scratch = '0; m_cmd = '0; m_mac0 = '0; m_mac1 = '0; m_mdio = '0; m_sw = 0;
      for (int a = 7; a <= 14; a++) m_thr[a] = '0;
      exp_busy = 1'b0; exp_phy_req = 1'b0; exp_phy_wr = 1'b0;
      exp_phy_dev = '0; exp_phy_reg = '0; exp_phy_wdata = '0; exp_readdata = '0;
   endtask

   // One clock: the software-reset countdown advances on each edge.
   task automatic tick();
      @(posedge clk);
      if (m_sw > 0) begin
         m_sw--;
         if (m_sw == 0) m_cmd[13] = 1'b0;
      end
      #1;
   endtask

   task automatic local_txn(input logic wr, input logic [7:0] a, input logic [31:0] d, input bit hold);
      logic [31:0] rd;
      reg_wr = wr; reg_rd = !wr; reg_addr = a; reg_writedata = d;
      tick();
      if (!hold) begin reg_wr = 1'b0; reg_rd = 1'b0; end
      exp_busy = 1'b1;
      rd = model_read(a);
      tick();
      exp_busy = 1'b0;
      if (wr) model_write(a, d);
      else    exp_readdata = rd;
      tick();
   endtask

   // done_at: PHY_WAIT cycle (0 = phy_req cycle) on which phy_done is driven; -1 = never.
   task automatic phy_txn(input logic wr, input logic [7:0] a, input logic [31:0] d,
                          input int done_at, input logic [15:0] rdata);
      int last;
      reg_wr = wr; reg_rd = !wr; reg_addr = a; reg_writedata = d;
      tick();
      reg_wr = 1'b0; reg_rd = 1'b0;
      exp_busy = 1'b1; exp_phy_req = 1'b1; exp_phy_wr = wr;
      exp_phy_dev = m_mdio; exp_phy_reg = a[4:0]; exp_phy_wdata = d[15:0];
      last = (done_at >= 0 && done_at < PHY_TIMEOUT) ? done_at : PHY_TIMEOUT - 1;
      for (int k = 0; k <= last; k++) begin
         if (k == done_at) begin phy_done = 1'b1; phy_rdata = rdata; end
         tick();
         phy_done = 1'b0;
         exp_phy_req = 1'b0;
      end
      exp_busy = 1'b0;
      if (!wr) exp_readdata = (done_at == last) ? {16'h0, rdata} : 32'h0000_FFFF;
      tick();
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy",      reg_busy,     exp_busy);
         check("readdata",  reg_readdata, exp_readdata);
         check("command",   cfg_command,  m_cmd);
         check("mac_addr",  cfg_mac_addr, {m_mac1, m_mac0});
         check("fifo_thr",  cfg_fifo_thr, thr_vec());
         check("phy_req",   phy_req,      exp_phy_req);
         check("phy_wr",    phy_wr,       exp_phy_wr);
         check("phy_dev",   phy_dev,      exp_phy_dev);
         check("phy_reg",   phy_reg,      exp_phy_reg);
         check("phy_wdata", phy_wdata,    exp_phy_wdata);
      end
   end

   initial begin
      checks = 0; errors = 0; chk_en = 1'b0;
      rst = 1'b1; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_writedata = '0;
      phy_done = 1'b0; phy_rdata = '0;
      model_reset();
      tick();
      tick();
      rst = 1'b0;
      model_reset();
      chk_en = 1'b1;

      check("rst_busy",     reg_busy,     1'b0);
      check("rst_readdata", reg_readdata, 32'h0);
      check("rst_command",  cfg_command,  32'h0);
      check("rst_mac",      cfg_mac_addr, 48'h0);
      check("rst_thr",      cfg_fifo_thr, 128'h0);
      check("rst_phy_req",  phy_req,      1'b0);

      // Held write request: two back-to-back transactions 3 cycles apart
      local_txn(1'b1, 8'd3, 32'h0615_0910, 1'b1);
      check("held_busy_idle", reg_busy, 1'b0);
      check("mac0_lit", cfg_mac_addr[31:0], 32'h0615_0910);
      local_txn(1'b1, 8'd3, 32'h0615_0910, 1'b0);

      local_txn(1'b1, 8'd4, 32'hFFFF_2019, 1'b0);
      local_txn(1'b0, 8'd4, 32'h0, 1'b0);
      check("mac1_read_lit", reg_readdata, 32'h0000_2019);
      check("mac1_cfg_lit",  cfg_mac_addr[47:32], 16'h2019);

      local_txn(1'b0, 8'd0, 32'h0, 1'b0);
      check("rev_lit", reg_readdata, 32'h0000_0901);
      local_txn(1'b1, 8'd1, 32'hDEAD_BEEF, 1'b0);
      local_txn(1'b1, 8'd7, 32'hABCD_1234, 1'b0);
      local_txn(1'b1, 8'd14, 32'h0000_BEEF, 1'b0);
      check("thr_lit", cfg_fifo_thr, {16'hBEEF, 96'h0, 16'h1234});
      local_txn(1'b0, 8'd14, 32'h0, 1'b0);
      local_txn(1'b1, 8'd5, 32'h1111_1111, 1'b0);
      local_txn(1'b1, 8'hA0, 32'h2222_2222, 1'b0);
      local_txn(1'b0, 8'hA0, 32'h0, 1'b0);
      check("unmapped_lit", reg_readdata, 32'h0);
      local_txn(1'b0, 8'd1, 32'h0, 1'b0);
      local_txn(1'b1, 8'd15, 32'h0000_0010, 1'b0);

      // Software reset: bit 13 held for SW_RESET_CYCLES, tx/rx enables forced low
      local_txn(1'b1, 8'd2, 32'h0400_2033, 1'b0);
      local_txn(1'b0, 8'd2, 32'h0, 1'b0);
      check("swrst_active_lit", reg_readdata, 32'h0400_2030);
      for (int i = 0; i < 7; i++) local_txn(1'b0, 8'd2, 32'h0, 1'b0);
      check("swrst_done_lit", reg_readdata, 32'h0400_0030);

      // Write with bit 13 clear while counting keeps bit 13 set, then reload
      local_txn(1'b1, 8'd2, 32'h0000_2001, 1'b0);
      local_txn(1'b0, 8'd2, 32'h0, 1'b0);
      local_txn(1'b0, 8'd2, 32'h0, 1'b0);
      local_txn(1'b1, 8'd2, 32'h0000_0003, 1'b0);
      local_txn(1'b0, 8'd2, 32'h0, 1'b0);
      check("swrst_keep_lit", reg_readdata, 32'h0000_2003);
      local_txn(1'b1, 8'd2, 32'h0000_2003, 1'b0);
      for (int i = 0; i < 7; i++) local_txn(1'b0, 8'd2, 32'h0, 1'b0);
      check("swrst_reload_lit", reg_readdata, 32'h0000_0000);

      // PHY write completed by phy_done 20 cycles after phy_req
      phy_txn(1'b1, 8'h84, 32'h0000_0001, 20, 16'h0);
      check("phy_dev_lit",   phy_dev,   5'h10);
      check("phy_reg_lit",   phy_reg,   5'h04);
      check("phy_wdata_lit", phy_wdata, 16'h0001);
      check("phy_wr_lit",    phy_wr,    1'b1);
      check("phy_wr_rd_lit", reg_readdata, 32'h0000_0000);

      phy_txn(1'b0, 8'h9F, 32'h0, 3, 16'h5A5A);
      check("phy_read_lit", reg_readdata, 32'h0000_5A5A);

      phy_txn(1'b0, 8'h80, 32'h0, -1, 16'h0);
      check("phy_timeout_lit", reg_readdata, 32'h0000_FFFF);

      // Reset in the middle of a PHY access; a late phy_done must be ignored
      reg_rd = 1'b1; reg_addr = 8'h90; reg_writedata = 32'h0;
      tick();
      reg_rd = 1'b0;
      exp_busy = 1'b1; exp_phy_req = 1'b1; exp_phy_wr = 1'b0;
      exp_phy_dev = m_mdio; exp_phy_reg = 5'h10; exp_phy_wdata = 16'h0;
      for (int i = 0; i < 5; i++) begin
         tick();
         exp_phy_req = 1'b0;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      check("mid_rst_busy", reg_busy,     1'b0);
      check("mid_rst_cmd",  cfg_command,  32'h0);
      check("mid_rst_mac",  cfg_mac_addr, 48'h0);
      check("mid_rst_thr",  cfg_fifo_thr, 128'h0);
      phy_done = 1'b1; phy_rdata = 16'h1234;
      tick();
      phy_done = 1'b0;
      tick();
      check("late_done_busy", reg_busy,     1'b0);
      check("late_done_rd",   reg_readdata, 32'h0);

      local_txn(1'b1, 8'd1, 32'h1234_5678, 1'b0);
      local_txn(1'b0, 8'd1, 32'h0, 1'b0);
      check("post_rst_lit", reg_readdata, 32'h1234_5678);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
